serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor: computes diff = a - b, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Companion to the team's combinational full-adder datapath cells; the arithmetic inverse, in serial form, for area-constrained paths.
- Sits between a requester that presents parallel operands with a start pulse and a consumer that samples the result on done.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor_cell.sv | 30 +++
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : control FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor built from gate primitives.
// Ports:
//   a, b  : minuend bit, subtrahend bit
//   bin   : borrow in from the less significant bit
//   d     : difference bit  a ^ b ^ bin
//   bout  : borrow out      (~a & b) | (~(a ^ b) & bin)
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;
  logic a_n;
  logic a_xnor_b;
  logic brw_gen;
  logic brw_prop;

  xor g_x0 (a_xor_b, a, b);
  xor g_x1 (d, a_xor_b, bin);
  not g_n0 (a_n, a);
  and g_a0 (brw_gen, a_n, b);
  // Equal operand bits pass the incoming borrow straight through.
  not g_n1 (a_xnor_b, a_xor_b);
  and g_a1 (brw_prop, a_xnor_b, bin);
  or  g_o0 (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, only sampled in IDLE
//   a, b         : operands, captured on the accepted start edge
//   busy         : high while bits are being processed
//   done         : one-cycle pulse, diff/borrow_out valid
//   diff         : difference, held until the next accepted start
//   borrow_out   : 1 iff a < b (unsigned), held until the final bit of the next op
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results of the last operation are held
// SHIFT | one bit per edge through the cell; cnt tracks the bit index
// DONE  | one-cycle result-valid pulse; always returns to IDLE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_r;
  logic [CNT_W-1:0]   cnt;
  logic               brw;
  logic               borrow_r;
  logic               d_bit;
  logic               bout_bit;
  logic               last_bit;

  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_r   <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          diff_r <= {d_bit, diff_r[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          brw    <= bout_bit;
          cnt    <= cnt + 1'b1;
          if (last_bit) borrow_r <= bout_bit;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, brw8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, brw4;
  logic [3:0] diff4;

  int tests = 0;
  int fails = 0;
  int last_brw = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(brw8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(brw4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b, input int w);
    return (a - b + (1 << w)) % (1 << w);
  endfunction

  function automatic int ref_brw(input int a, input int b);
    return (a < b) ? 1 : 0;
  endfunction

  task automatic op8(input int a, input int b);
    int n;
    @(negedge clk);
    a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy_accept", busy8, 1);
    check("diff_clear", diff8, 0);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      if (n == 3) check("brw_hold_shift", brw8, last_brw);
      @(posedge clk); #1;
      n++;
    end
    check("latency8", n, 8);
    check("diff8", diff8, ref_diff(a, b, 8));
    check("brw8", brw8, ref_brw(a, b));
    check("busy_done", busy8, 0);
    last_brw = ref_brw(a, b);
    @(posedge clk); #1;
    check("done_1cyc", done8, 0);
    check("diff_hold", diff8, ref_diff(a, b, 8));
  endtask

  task automatic op4(input int a, input int b);
    int n;
    @(negedge clk);
    a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency4", n, 4);
    check("diff4", diff4, ref_diff(a, b, 4));
    check("brw4", brw4, ref_brw(a, b));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, ndone, nbusy, ra, rb;

    // Reset values while rst_n is low.
    #3;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_brw", brw8, 0);
    check("rst_diff4", diff4, 0);
    #19 rst_n = 1'b1;

    // Directed arithmetic and corners.
    op8(100, 37);
    op8(5, 10);
    op8(0, 1);
    op8(255, 255);
    op8(0, 0);
    op8(128, 127);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      op8(ra, rb);
    end

    // Start and operand changes during SHIFT, start in DONE: all ignored.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd3; b8 = 8'd9;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_latency", n, 5);
    check("ign_diff", diff8, 187);
    check("ign_brw", brw8, 0);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1) ndone++;
      if (busy8 === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
    check("ign_no_done", ndone, 0);
    check("ign_no_busy", nbusy, 0);
    check("ign_diff_hold", diff8, 187);
    last_brw = 0;

    // Borrow set, then reset asynchronously at bit 3 of the next op.
    op8(5, 10);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_diff", diff8, 0);
    check("mid_rst_brw", brw8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) ndone++;
      if (busy8 === 1'b1) nbusy++;
    end
    check("mid_rst_no_done", ndone, 0);
    check("mid_rst_idle", nbusy, 0);
    last_brw = 0;

    // Back-to-back with start held high.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd50; start8 = 1'b1;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_lat", n, 9);
    check("b2b_diff1", diff8, 150);
    check("b2b_brw1", brw8, 0);
    a8 = 8'd50; b8 = 8'd200;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done8 !== 1'b1 && n < 30);
    start8 = 1'b0;
    check("b2b_spacing", n, 10);
    check("b2b_diff2", diff8, 106);
    check("b2b_brw2", brw8, 1);
    @(posedge clk); #1;
    check("b2b_done_1cyc", done8, 0);
    @(posedge clk); #1;
    check("b2b_idle", busy8, 0);

    // Exhaustive sweep on the 4-bit instance.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(x, y);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
